rv32_regfile_wb: RTL and testbench
==================================

RV32_REGFILE_WB -- requirements
Module: rv32_regfile_wb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the register and datapath width in bits (minimum 16).
REQ-002 The block SHALL have parameter NREG, default 32, giving the register count; legal values are 16 (RV32E) or 32. AW = log2(NREG).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  request a read/write-back transaction; sampled only when accepted (REQ-014).
REQ-007 load, store  in  1 each  instruction class for effective-address generation.
REQ-008 sel_s1, sel_s2, sel_d1  in  AW each  source and destination register indices.
REQ-009 wr_en  in  1  destination write enable for this transaction.
REQ-010 instr  in  32  instruction word supplying the I/S immediates.
REQ-011 alu_d, bshift_d, pc_d, data_d  in  XLEN each  write-back sources 0..3.
REQ-012 src_sel  in  2  write-back source select.
REQ-013 reg_s1, reg_s2, data_addr  out  XLEN each; busy, done  out  1 each; src_sel_q  out  2 (latched source select).

Function
REQ-014 The FSM SHALL have states IDLE, READ and WB; start is accepted in IDLE (and, with bypass, in WB), and is ignored in READ.
REQ-015 On acceptance, the block SHALL register reg_s1/reg_s2 (0 when the index is 0), and SHALL capture sel_d1, wr_en and src_sel into internal/output latches; the FSM SHALL go to READ.
REQ-016 READ SHALL last exactly one cycle and then go to WB; busy SHALL be 1 in READ.
REQ-017 In the WB cycle the block SHALL write source[src_sel_q] into the captured rd when wr_en_q=1 and rd!=0; done SHALL pulse high for exactly that one cycle.
REQ-018 After WB the FSM SHALL go to IDLE, or to READ if a start was accepted in WB.
REQ-019 Register 0 SHALL always read 0 and SHALL never be written.
REQ-020 On acceptance with store=1, data_addr SHALL be set to sext(instr[31:25],instr[11:7]) + rs1; otherwise with load=1, sext(instr[31:20]) + rs1; with neither set, data_addr SHALL hold. Store SHALL win when both are set.
REQ-021 Address arithmetic SHALL be modulo 2^XLEN; the 12-bit immediate SHALL be sign-extended to XLEN; rs1 SHALL be taken as 0 when sel_s1=0.
REQ-022 The total latency from start acceptance to done SHALL be 2 cycles; reg_s1, reg_s2 and data_addr SHALL be valid from the cycle after acceptance until the next acceptance.

Reset
REQ-023 While rst=1, the block SHALL hold the FSM in IDLE and SHALL drive busy=0, done=0, src_sel_q=0, reg_s1=0, reg_s2=0 and data_addr=0; all registers SHALL be cleared to 0.
REQ-024 A reset asserted in READ or WB SHALL abort the transaction with no register write.

Configuration
REQ-025 When RF_BYPASS_EN is defined: busy SHALL be 0 in WB; start SHALL be accepted in WB; any read of the rd being written in that cycle (reg_s1, reg_s2, and the data_addr base) SHALL return the write data.
REQ-026 When RF_BYPASS_EN is undefined: busy SHALL be 1 in both READ and WB; start SHALL be ignored in WB; there SHALL be no forwarding path.

Verification
REQ-027 Reset, then write x5=0x0000_1234 via alu_d (src_sel=0, wr_en=1) -> done at cycle+2; a later read with sel_s1=5 gives reg_s1=0x0000_1234.
REQ-028 Write 0xDEAD_BEEF to rd=0 -> a read of x0 still gives 0; done still pulses once.
REQ-029 x2=0x100, load, instr[31:20]=0xFFC -> data_addr=0x0000_00FC; store with imm 0x008 -> data_addr=0x0000_0108; load and store both set -> the store address is used.
REQ-030 start held high for 6 cycles, macro off -> exactly 2 transactions, busy pattern 1,1,0; macro on -> 3 transactions, back-to-back.
REQ-031 Macro on: WB writes x7=0x55 while a start with sel_s1=7 is accepted -> reg_s1=0x55 the next cycle.
REQ-032 Assert rst during READ -> no write occurs, all outputs are 0, and the next transaction proceeds normally.

Source files
------------

// File: rtl/rv32_regfile_wb.sv
// RV32 register file with read / write-back sequencer and load/store address generation.
// Optional macro RF_BYPASS_EN: accept start in WB and forward the write-back data to same-cycle reads.
module rv32_regfile_wb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            load,
  input  logic            store,
  input  logic [AW-1:0]   sel_s1,
  input  logic [AW-1:0]   sel_s2,
  input  logic [AW-1:0]   sel_d1,
  input  logic            wr_en,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] alu_d,
  input  logic [XLEN-1:0] bshift_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] data_d,
  input  logic [1:0]      src_sel,
  output logic [XLEN-1:0] reg_s1,
  output logic [XLEN-1:0] reg_s2,
  output logic [XLEN-1:0] data_addr,
  output logic            busy,
  output logic            done,
  output logic [1:0]      src_sel_q
);

  typedef enum logic [1:0] {IDLE, READ, WB} state_t;

  state_t          state;
  logic [XLEN-1:0] rf [NREG];
  logic [AW-1:0]   rd_q;
  logic            wr_en_q;
  logic [XLEN-1:0] wb_data, rs1_v, rs2_v, imm_i, imm_s;
  logic            wb_we, accept;

  always_comb begin
    wb_data = alu_d;
    case (src_sel_q)
      2'd0: wb_data = alu_d;
      2'd1: wb_data = bshift_d;
      2'd2: wb_data = pc_d;
      default: wb_data = data_d;
    endcase
  end

  assign wb_we = (state == WB) && wr_en_q && (rd_q != '0);
  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};

`ifdef RF_BYPASS_EN
  assign accept = start && (state == IDLE || state == WB);

  // A read of the register being written this cycle sees the new value.
  always_comb begin
    rs1_v = (sel_s1 == '0) ? '0 : rf[sel_s1];
    rs2_v = (sel_s2 == '0) ? '0 : rf[sel_s2];
    if (wb_we && sel_s1 == rd_q) rs1_v = wb_data;
    if (wb_we && sel_s2 == rd_q) rs2_v = wb_data;
  end
`else
  assign accept = start && (state == IDLE);

  always_comb begin
    rs1_v = (sel_s1 == '0) ? '0 : rf[sel_s1];
    rs2_v = (sel_s2 == '0) ? '0 : rf[sel_s2];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      src_sel_q <= 2'd0;
      reg_s1    <= '0;
      reg_s2    <= '0;
      data_addr <= '0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      done <= 1'b0;
      if (wb_we) rf[rd_q] <= wb_data;
      case (state)
        IDLE: if (accept) begin
          state <= READ;
          busy  <= 1'b1;
        end
        READ: begin
          state <= WB;
          done  <= 1'b1;
`ifdef RF_BYPASS_EN
          busy  <= 1'b0;
`else
          busy  <= 1'b1;
`endif
        end
        default: begin
          state <= accept ? READ : IDLE;
          busy  <= accept;
        end
      endcase
      if (accept) begin
        reg_s1    <= rs1_v;
        reg_s2    <= rs2_v;
        rd_q      <= sel_d1;
        wr_en_q   <= wr_en;
        src_sel_q <= src_sel;
        // Store wins over load; with neither, the last address holds.
        if (store)     data_addr <= rs1_v + imm_s;
        else if (load) data_addr <= rs1_v + imm_i;
      end
    end
  end

endmodule

// File: tb/tb_rv32_regfile_wb.sv
// Randomized bench for rv32_regfile_wb against a transaction-level register-file model.
module tb_rv32_regfile_wb;
  localparam int XLEN = 32;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rst;
  logic start, load, store, wr_en;
  logic [4:0] sel_s1, sel_s2, sel_d1;
  logic [31:0] instr;
  logic [XLEN-1:0] alu_d, bshift_d, pc_d, data_d;
  logic [1:0] src_sel, src_sel_q;
  logic [XLEN-1:0] reg_s1, reg_s2, data_addr;
  logic busy, done;

  rv32_regfile_wb #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .rst(rst), .start(start), .load(load), .store(store),
    .sel_s1(sel_s1), .sel_s2(sel_s2), .sel_d1(sel_d1), .wr_en(wr_en),
    .instr(instr), .alu_d(alu_d), .bshift_d(bshift_d), .pc_d(pc_d),
    .data_d(data_d), .src_sel(src_sel), .reg_s1(reg_s1), .reg_s2(reg_s2),
    .data_addr(data_addr), .busy(busy), .done(done), .src_sel_q(src_sel_q)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [XLEN-1:0] mdl [32];
  logic [XLEN-1:0] exp_addr;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] rd_mdl(input logic [4:0] s);
    return (s == 0) ? '0 : mdl[s];
  endfunction

  // Immediate as a signed integer, added to the base modulo 2^XLEN.
  function automatic logic [XLEN-1:0] ea(input logic [XLEN-1:0] base, input logic [11:0] imm12);
    logic signed [11:0] si;
    int off;
    si  = imm12;
    off = si;
    return base + XLEN'(off);
  endfunction

  function automatic void mdl_clear();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    exp_addr = '0;
  endfunction

  // One full transaction: accept, READ, WB, back to IDLE, with model update after WB.
  task automatic txn(input logic [4:0] s1, s2, d, input logic we, input logic [1:0] ss,
                     input logic ld, st, input logic [31:0] ins,
                     input logic [XLEN-1:0] a, b, p, dd);
    logic [XLEN-1:0] src [4];
    logic [XLEN-1:0] base;
    @(negedge clk);
    sel_s1 = s1; sel_s2 = s2; sel_d1 = d; wr_en = we; src_sel = ss;
    load = ld; store = st; instr = ins;
    alu_d = a; bshift_d = b; pc_d = p; data_d = dd;
    start = 1'b1;
    src[0] = a; src[1] = b; src[2] = p; src[3] = dd;
    base = rd_mdl(s1);
    if (st)      exp_addr = ea(base, {ins[31:25], ins[11:7]});
    else if (ld) exp_addr = ea(base, ins[31:20]);
    @(negedge clk);
    start = 1'b0;
    chk("read_busy", XLEN'(busy), 1);
    chk("read_done", XLEN'(done), 0);
    chk("reg_s1", reg_s1, base);
    chk("reg_s2", reg_s2, rd_mdl(s2));
    chk("data_addr", data_addr, exp_addr);
    chk("src_sel_q", XLEN'(src_sel_q), XLEN'(ss));
    @(negedge clk);
    chk("wb_done", XLEN'(done), 1);
    chk("wb_busy", XLEN'(busy), BYP ? 0 : 1);
    if (we && d != 0) mdl[d] = src[ss];
    @(negedge clk);
    chk("idle_done", XLEN'(done), 0);
    chk("idle_busy", XLEN'(busy), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, XLEN'(busy), 0);
    chk({tag, "_done"}, XLEN'(done), 0);
    chk({tag, "_s1"}, reg_s1, 0);
    chk({tag, "_s2"}, reg_s2, 0);
    chk({tag, "_addr"}, data_addr, 0);
    chk({tag, "_ssq"}, XLEN'(src_sel_q), 0);
  endtask

  initial begin
    int dn;
    logic [5:0] busy_exp;
    rst = 1'b1; start = 0; load = 0; store = 0; wr_en = 0;
    sel_s1 = 0; sel_s2 = 0; sel_d1 = 0; instr = 0; src_sel = 0;
    alu_d = 0; bshift_d = 0; pc_d = 0; data_d = 0;
    mdl_clear();
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;

    // Directed: write x5 via alu_d, read it back.
    txn(0, 0, 5, 1, 0, 0, 0, 0, 32'h0000_1234, 1, 2, 3);
    txn(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x5_const", reg_s1, 32'h0000_1234);

    // x0 is never written.
    txn(0, 0, 0, 1, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_zero", reg_s1, 0);

    // Address generation.
    txn(0, 0, 2, 1, 2, 0, 0, 0, 0, 0, 32'h100, 0);
    txn(2, 0, 0, 0, 0, 1, 0, 32'hFFC0_0000, 0, 0, 0, 0);
    chk("load_addr", data_addr, 32'h0000_00FC);
    txn(2, 0, 0, 0, 0, 0, 1, 32'h0000_0400, 0, 0, 0, 0);
    chk("store_addr", data_addr, 32'h0000_0108);
    txn(2, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("hold_addr", data_addr, 32'h0000_0108);
    txn(2, 0, 0, 0, 0, 1, 1, 32'h0010_0400, 0, 0, 0, 0);
    chk("both_addr", data_addr, 32'h0000_0108);

    // Randomized transactions.
    for (int n = 0; n < 150; n++)
      txn(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 2'($urandom),
          1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom);

    // start held high for 6 cycles.
    busy_exp = BYP ? 6'b010101 : 6'b011011;
    dn = 0;
    @(negedge clk);
    sel_d1 = 0; wr_en = 0; load = 0; store = 0; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold_busy%0d", i), XLEN'(busy), XLEN'(busy_exp[i]));
      dn += int'(done);
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("hold_txns", XLEN'(dn), BYP ? 3 : 2);

`ifdef RF_BYPASS_EN
    // Forwarding: start accepted during the WB that writes x7.
    @(negedge clk);
    sel_d1 = 7; wr_en = 1; src_sel = 0; alu_d = 32'h55; sel_s1 = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("fwd_wb_done", XLEN'(done), 1);
    sel_s1 = 7; sel_s2 = 7; load = 1; store = 0; instr = 32'h0040_0000; wr_en = 0; start = 1'b1;
    mdl[7] = 32'h55;
    @(negedge clk);
    start = 1'b0; load = 0;
    chk("fwd_s1", reg_s1, 32'h55);
    chk("fwd_s2", reg_s2, 32'h55);
    chk("fwd_addr", data_addr, 32'h59);
    exp_addr = 32'h59;
    repeat (2) @(negedge clk);
`endif

    // Reset during READ aborts the write.
    @(negedge clk);
    sel_d1 = 9; wr_en = 1; src_sel = 0; alu_d = 32'hAAAA_5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outs("rst_read");
    @(negedge clk);
    rst = 1'b0;
    mdl_clear();
    repeat (2) @(negedge clk);
    txn(9, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x9_not_written", reg_s1, 0);
    txn(0, 0, 9, 1, 3, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D);
    txn(9, 0, 0, 0, 0, 1, 0, 32'h0010_0000, 0, 0, 0, 0);
    chk("after_rst_x9", reg_s1, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
